// File: rtl/capture_fb_writer_pkg.sv
// Shared definitions for the capture framebuffer writer: default geometry,
// bank index type, FSM state encoding and buffer sizing helper.
package capture_fb_writer_pkg;

  localparam int H_ACTIVE_DEF = 224;
  localparam int V_ACTIVE_DEF = 144;

  typedef logic [1:0] bank_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Number of BRAM words one frame bank occupies (last word may be partial).
  function automatic int words_per_buf(input int total, input int ppw);
    return (total + ppw - 1) / ppw;
  endfunction

endpackage

// File: rtl/capture_fb_writer_pixel_packer.sv
// Packs PXL_PER_WORD pixels into one BRAM word (slot 0 in the low bits),
// flushes early on the last pixel of a frame with zero padding, and emits
// a registered one-cycle write strobe with its word address.
module capture_fb_writer_pixel_packer
  import capture_fb_writer_pkg::*;
#(
  parameter int PXL_W        = 12,
  parameter int PXL_PER_WORD = 3,
  parameter int ADDR_W       = 16
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          clear,
  input  logic                          pix_vld,
  input  logic [PXL_W-1:0]              pix_data,
  input  logic                          pix_last,
  input  logic [ADDR_W-1:0]             base_addr,
  output logic                          word_vld,
  output logic [ADDR_W-1:0]             word_addr,
  output logic [PXL_W*PXL_PER_WORD-1:0] word_data
);

  localparam int WORD_W = PXL_W * PXL_PER_WORD;
  localparam int SLOT_W = (PXL_PER_WORD > 1) ? $clog2(PXL_PER_WORD) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PXL_PER_WORD - 1);

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;

  // Fill the current slot; on a full word or frame end, latch the word out
  // and start the next one from an all-zero accumulator.
  always_comb begin
    slot_d = slot_q;
    acc_d  = acc_q;
    idx_d  = idx_q;
    vld_d  = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (clear) begin
      slot_d = '0;
      acc_d  = '0;
      idx_d  = '0;
    end
    if (pix_vld) begin
      for (int s = 0; s < PXL_PER_WORD; s++) begin
        if (slot_d == SLOT_W'(s)) acc_d[s*PXL_W +: PXL_W] = pix_data;
      end
      if (slot_d == SLOT_LAST || pix_last) begin
        vld_d  = 1'b1;
        data_d = acc_d;
        addr_d = base_addr + idx_d;
        idx_d  = idx_d + ADDR_W'(1);
        slot_d = '0;
        acc_d  = '0;
      end else begin
        slot_d = slot_d + SLOT_W'(1);
      end
    end
  end

  // Packer state and write-port registers; reset drops any pending word.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      slot_q <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      slot_q <= slot_d;
      acc_q  <= acc_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign word_vld  = vld_q;
  assign word_addr = addr_q;
  assign word_data = data_q;

endmodule

// File: rtl/capture_fb_writer.sv
// Framebuffer write controller between video capture and the BRAM write
// port. Tracks frame geometry, rejects malformed frames, and rotates
// NUM_BUF banks so readout only ever sees complete frames.
module capture_fb_writer
  import capture_fb_writer_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int PXL_W        = 12,
  parameter int PXL_PER_WORD = 3,
  parameter int NUM_BUF      = 3,
  parameter int ADDR_W       = 16
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          pxlValid,
  input  logic [PXL_W-1:0]              pxlData,
  input  logic                          lineStart,
  input  logic                          frameStart,
  input  logic                          rdFrameStart,
  input  logic                          freeze,
  output logic                          wrEn,
  output logic [ADDR_W-1:0]             wrAddr,
  output logic [PXL_W*PXL_PER_WORD-1:0] wrData,
  output logic [1:0]                    rdBank,
  output logic [7:0]                    frameCnt,
  output logic [7:0]                    errCnt
);

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int WPB   = words_per_buf(TOTAL, PXL_PER_WORD);
  localparam int X_W   = $clog2(H_ACTIVE + 1);
  localparam int Y_W   = $clog2(V_ACTIVE + 1);
  localparam int P_W   = $clog2(TOTAL + 1);

  localparam logic [X_W-1:0]    X_END    = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]    Y_END    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(V_ACTIVE - 1);
  localparam logic [P_W-1:0]    P_END    = P_W'(TOTAL);
  localparam logic [P_W-1:0]    P_LAST   = P_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] WPB_A    = ADDR_W'(WPB);
  localparam bank_t             BANK_RST = (NUM_BUF == 1) ? 2'd0 : 2'd1;

  if (NUM_BUF < 1 || NUM_BUF > 3) begin : g_bad_num_buf
    $error("capture_fb_writer: NUM_BUF must be 1, 2 or 3");
  end
  if (longint'(NUM_BUF) * longint'(WPB) > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
    $error("capture_fb_writer: NUM_BUF banks do not fit in ADDR_W address space");
  end

  state_t          state_q, state_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [P_W-1:0]  p_q, p_d;
  logic            bad_q, bad_d;
  bank_t           wr_bank_q, wr_bank_d;
  bank_t           latest_q, latest_d;
  bank_t           rd_bank_q, rd_bank_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic            restart;
  logic            close_good;
  logic            pix_ok;
  logic            pix_last;
  logic [ADDR_W-1:0] base_addr;

  // Frame FSM, geometry counters, frame closure, bank rotation and readout
  // bank selection. Frame events are resolved before the same-cycle pixel,
  // so a pixel arriving with frameStart/lineStart belongs to the new one.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    p_d         = p_q;
    bad_d       = bad_q;
    wr_bank_d   = wr_bank_q;
    latest_d    = latest_q;
    rd_bank_d   = rd_bank_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    restart     = 1'b0;
    close_good  = 1'b0;
    pix_ok      = 1'b0;
    pix_last    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frameStart) begin
          state_d = ST_ACTIVE;
          restart = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (frameStart) begin
          restart = 1'b1;
          // First line has no lineStart, so a complete frame ends on V_ACTIVE-1.
          if (!bad_q && p_q == P_END && y_q == Y_LAST) begin
            close_good = 1'b1;
          end else if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else if (lineStart) begin
          if (x_q != X_END) bad_d = 1'b1;
          x_d = '0;
          // Saturate so surplus lines can never wrap back to a valid count.
          if (y_q != Y_END) y_d = y_q + Y_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      x_d   = '0;
      y_d   = '0;
      p_d   = '0;
      bad_d = 1'b0;
    end

    if (close_good) begin
      latest_d    = wr_bank_q;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    // Same-cycle closure bypasses straight to the freshly completed bank.
    if (rdFrameStart && !freeze) begin
      rd_bank_d = close_good ? wr_bank_q : latest_q;
    end

    // Next write bank avoids both the displayed and the newest frame.
    if (close_good) begin
      if (NUM_BUF == 1) begin
        wr_bank_d = 2'd0;
      end else if (NUM_BUF == 2) begin
        wr_bank_d = (wr_bank_q == 2'd0) ? 2'd1 : 2'd0;
      end else if (rd_bank_d != wr_bank_q) begin
        wr_bank_d = 2'd3 - rd_bank_d - wr_bank_q;
      end else begin
        wr_bank_d = (wr_bank_q == 2'd2) ? 2'd0 : wr_bank_q + 2'd1;
      end
    end

    if (pxlValid && state_d == ST_ACTIVE && x_d < X_END && y_d < Y_END) begin
      pix_ok   = 1'b1;
      pix_last = (p_d == P_LAST);
      x_d      = x_d + X_W'(1);
      p_d      = p_d + P_W'(1);
    end
  end

  assign base_addr = ADDR_W'(wr_bank_d) * WPB_A;

  // Control and status registers; asynchronous reset returns to idle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      p_q         <= '0;
      bad_q       <= 1'b0;
      wr_bank_q   <= BANK_RST;
      latest_q    <= 2'd0;
      rd_bank_q   <= 2'd0;
      frame_cnt_q <= 8'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      p_q         <= p_d;
      bad_q       <= bad_d;
      wr_bank_q   <= wr_bank_d;
      latest_q    <= latest_d;
      rd_bank_q   <= rd_bank_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  capture_fb_writer_pixel_packer #(
    .PXL_W        (PXL_W),
    .PXL_PER_WORD (PXL_PER_WORD),
    .ADDR_W       (ADDR_W)
  ) u_packer (
    .clk       (clk),
    .rstN      (rstN),
    .clear     (restart),
    .pix_vld   (pix_ok),
    .pix_data  (pxlData),
    .pix_last  (pix_last),
    .base_addr (base_addr),
    .word_vld  (wrEn),
    .word_addr (wrAddr),
    .word_data (wrData)
  );

  assign rdBank   = rd_bank_q;
  assign frameCnt = frame_cnt_q;
  assign errCnt   = err_cnt_q;

endmodule

// File: tb/tb_capture_fb_writer.sv
// Directed bench for capture_fb_writer on a reduced 5x4 geometry
// (20 pixels, 7 words per bank, last word partial).
module tb_capture_fb_writer;

  localparam int H     = 5;
  localparam int V     = 4;
  localparam int TOTAL = H * V;
  localparam int WPB   = 7;

  logic        clk = 1'b0;
  logic        rstN;
  logic        pxlValid;
  logic [11:0] pxlData;
  logic        lineStart;
  logic        frameStart;
  logic        rdFrameStart;
  logic        freeze;
  logic        wrEn;
  logic [15:0] wrAddr;
  logic [35:0] wrData;
  logic [1:0]  rdBank;
  logic [7:0]  frameCnt;
  logic [7:0]  errCnt;

  capture_fb_writer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .PXL_W(12), .PXL_PER_WORD(3), .NUM_BUF(3), .ADDR_W(16)
  ) dut (
    .clk(clk), .rstN(rstN), .pxlValid(pxlValid), .pxlData(pxlData),
    .lineStart(lineStart), .frameStart(frameStart), .rdFrameStart(rdFrameStart),
    .freeze(freeze), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .rdBank(rdBank), .frameCnt(frameCnt), .errCnt(errCnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [35:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int addr, input logic [35:0] data, input int c);
    exp_t e;
    e.addr = 16'(addr);
    e.data = data;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Write monitor: every write must match the next expected entry, appear
  // exactly one cycle after its completing pixel, and avoid the read bank.
  always @(negedge clk) begin
    if (rstN && wrEn) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", wrAddr, wrData);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(wrAddr), 64'(mon_e.addr));
        chk("wr_data", 64'(wrData), 64'(mon_e.data));
        chk("wr_latency_cycle", 64'(cyc), 64'(mon_e.cyc));
        checks++;
        if ((int'(wrAddr) / WPB) == int'(rdBank)) begin
          errors++;
          $display("FAIL wr_bank_vs_rd: got write bank %0d, required different from rdBank %0d",
                   int'(wrAddr) / WPB, rdBank);
        end
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    pxlValid = 1'b0; pxlData = '0; lineStart = 1'b0; frameStart = 1'b0; rdFrameStart = 1'b0;
  endtask

  task automatic px(input logic [11:0] d, input logic fs, input logic rfs);
    @(negedge clk);
    pxlValid = 1'b1; pxlData = d; lineStart = 1'b0; frameStart = fs; rdFrameStart = rfs;
  endtask

  task automatic rd_pulse();
    @(negedge clk);
    pxlValid = 1'b0; lineStart = 1'b0; frameStart = 1'b0; rdFrameStart = 1'b1;
    idle();
  endtask

  // Sends one frame (frameStart/lineStart coincide with the first pixel of
  // each line), optionally one pixel short on line short_line, and queues
  // the words it should produce in bank `bank`.
  task automatic send_frame(input int tag, input int short_line, input int bank,
                            input logic rd_at_start, input int exp_rd);
    int          k = 0;
    int          slot = 0;
    int          word = 0;
    logic [35:0] acc = '0;
    logic [11:0] d;
    logic        rd_chk = 1'b0;
    for (int l = 0; l < V; l++) begin
      for (int i = 0; i < ((l == short_line) ? H - 1 : H); i++) begin
        @(negedge clk);
        if (rd_chk) begin
          chk("rd_bypass_same_update", 64'(rdBank), 64'(exp_rd));
          rd_chk = 1'b0;
        end
        d = {4'(tag), 8'(k)};
        pxlValid     = 1'b1;
        pxlData      = d;
        frameStart   = (l == 0 && i == 0);
        lineStart    = (l > 0 && i == 0);
        rdFrameStart = rd_at_start && (l == 0 && i == 0);
        if (l == 0 && i == 0 && exp_rd >= 0) rd_chk = 1'b1;
        acc[slot*12 +: 12] = d;
        slot++;
        k++;
        if (slot == 3 || k == TOTAL) begin
          push_exp(bank * WPB + word, acc, cyc + 1);
          word++;
          slot = 0;
          acc  = '0;
        end
      end
      idle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rstN = 1'b0; pxlValid = 1'b0; pxlData = '0; lineStart = 1'b0;
    frameStart = 1'b0; rdFrameStart = 1'b0; freeze = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wrEn", 64'(wrEn), 64'd0);
    chk("rst_wrAddr", 64'(wrAddr), 64'd0);
    chk("rst_wrData", 64'(wrData), 64'd0);
    chk("rst_rdBank", 64'(rdBank), 64'd0);
    chk("rst_frameCnt", 64'(frameCnt), 64'd0);
    chk("rst_errCnt", 64'(errCnt), 64'd0);
    rstN = 1'b1;

    // Two good frames into banks 1 then 2; third frame closes the second.
    send_frame(1, -1, 1, 1'b0, -1);
    send_frame(2, -1, 2, 1'b0, -1);
    send_frame(3, 1, 1, 1'b0, -1);   // short line 1 -> rejected later
    chk("frameCnt_after_two", 64'(frameCnt), 64'd2);
    rd_pulse();
    chk("rdBank_latest", 64'(rdBank), 64'd2);

    // Rejected frame: bank 1 reused, counters.
    send_frame(4, -1, 1, 1'b0, -1);
    chk("errCnt_short_line", 64'(errCnt), 64'd1);
    chk("frameCnt_unchanged", 64'(frameCnt), 64'd2);

    // Freeze: displayed bank 2 held while frames keep rotating through 0/1.
    freeze = 1'b1;
    send_frame(5, -1, 0, 1'b0, -1);
    rd_pulse();
    chk("freeze_rd_1", 64'(rdBank), 64'd2);
    send_frame(6, -1, 1, 1'b0, -1);
    rd_pulse();
    chk("freeze_rd_2", 64'(rdBank), 64'd2);
    send_frame(7, -1, 0, 1'b0, -1);
    rd_pulse();
    chk("freeze_rd_3", 64'(rdBank), 64'd2);
    chk("frameCnt_freeze", 64'(frameCnt), 64'd5);
    freeze = 1'b0;

    // Closure of frame 7 (bank 0) coincides with rdFrameStart.
    send_frame(8, -1, 1, 1'b1, 0);
    chk("frameCnt_bypass", 64'(frameCnt), 64'd6);

    // Hand vector: closes frame 8 (bank 1); next bank is 2 -> addr 14.
    px(12'h111, 1'b1, 1'b0);
    px(12'h222, 1'b0, 1'b0);
    px(12'h333, 1'b0, 1'b0);
    push_exp(2 * WPB, 36'h333222111, cyc + 1);
    px(12'h444, 1'b0, 1'b1);
    px(12'h555, 1'b0, 1'b0);
    idle();
    chk("rdBank_before_reset", 64'(rdBank), 64'd1);
    chk("frameCnt_before_reset", 64'(frameCnt), 64'd7);

    // Reset mid-line: outputs clear immediately, pending word is dropped.
    rstN = 1'b0;
    #1;
    chk("midrst_wrEn", 64'(wrEn), 64'd0);
    chk("midrst_wrAddr", 64'(wrAddr), 64'd0);
    chk("midrst_wrData", 64'(wrData), 64'd0);
    chk("midrst_rdBank", 64'(rdBank), 64'd0);
    chk("midrst_frameCnt", 64'(frameCnt), 64'd0);
    chk("midrst_errCnt", 64'(errCnt), 64'd0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;

    send_frame(10, -1, 1, 1'b0, -1);
    @(negedge clk);
    frameStart = 1'b1;
    idle();
    chk("post_reset_frameCnt", 64'(frameCnt), 64'd1);
    chk("post_reset_errCnt", 64'(errCnt), 64'd0);
    rd_pulse();
    chk("post_reset_rdBank", 64'(rdBank), 64'd1);

    repeat (4) @(negedge clk);
    chk("expected_writes_left", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
